// File: rtl/roce_stack_dm_cmd_scheduler.sv
// Splits translated RDMA requests into page-bounded AXI data-mover commands,
// limits in-flight commands by credit and retires them from the status stream.
//
//   state   | meaning
//   S_IDLE  | waiting for a request; req_ready_o high
//   S_ISSUE | emitting page-bounded chunks of the registered request
module roce_stack_dm_cmd_scheduler #(
   parameter int unsigned PAGE_BYTES      = 4096,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic [63:0]   req_addr_i,
   input  logic [27:0]   req_len_i,
   input  logic          req_ctl_i,
   output logic          cmd_valid_o,
   input  logic          cmd_ready_i,
   output logic [103:0]  cmd_data_o,
   input  logic          sts_valid_i,
   output logic          sts_ready_o,
   input  logic [7:0]    sts_data_i,
   output logic [3:0]    outstanding_o,
   output logic          idle_o,
   output logic          err_o,
   output logic [3:0]    err_tag_o
);

   localparam int unsigned PB_W = $clog2(PAGE_BYTES);

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t        state_q;
   logic [63:0]   addr_q;
   logic [27:0]   rem_q;
   logic          ctl_q;
   logic [3:0]    tag_q;
   logic [3:0]    out_q;
   logic          err_q;
   logic [3:0]    err_tag_q;

   logic [PB_W-1:0] offset;
   logic [22:0]     space;
   logic [22:0]     chunk;
   logic            last_chunk;
   logic            credit_ok;
   logic            cmd_hs;
   logic            sts_bad;
   logic            underflow;

   assign offset     = addr_q[PB_W-1:0];
   assign space      = 23'(PAGE_BYTES) - 23'(offset);
   assign chunk      = (rem_q < {5'd0, space}) ? rem_q[22:0] : space;
   assign last_chunk = ({5'd0, chunk} == rem_q);
   assign credit_ok  = (out_q < 4'(MAX_OUTSTANDING));
   assign cmd_hs     = cmd_valid_o && cmd_ready_i;
   assign sts_bad    = (sts_data_i[6:4] != 3'd0) || !sts_data_i[7];
   // A beat with nothing in flight (and no issue to cover it) is an underflow.
   assign underflow  = sts_valid_i && !cmd_hs && (out_q == 4'd0);

   assign req_ready_o   = (state_q == S_IDLE);
   assign cmd_valid_o   = (state_q == S_ISSUE) && credit_ok;
   assign cmd_data_o    = (state_q == S_ISSUE) ?
                          {4'd0, tag_q, addr_q, 1'b0, last_chunk & ctl_q, 6'd0, 1'b1, chunk} :
                          104'd0;
   assign sts_ready_o   = 1'b1;
   assign outstanding_o = out_q;
   assign idle_o        = (state_q == S_IDLE) && (out_q == 4'd0);
   assign err_o         = err_q;
   assign err_tag_o     = err_tag_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         ctl_q     <= 1'b0;
         tag_q     <= '0;
         out_q     <= '0;
         err_q     <= 1'b0;
         err_tag_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  addr_q <= req_addr_i;
                  rem_q  <= req_len_i;
                  ctl_q  <= req_ctl_i;
                  if (req_len_i != 28'd0) state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_hs) begin
                  addr_q <= addr_q + {41'd0, chunk};
                  rem_q  <= rem_q - {5'd0, chunk};
                  tag_q  <= tag_q + 4'd1;
                  if (last_chunk) state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         case ({cmd_hs, sts_valid_i})
            2'b10:   out_q <= out_q + 4'd1;
            2'b01:   if (out_q != 4'd0) out_q <= out_q - 4'd1;
            default: out_q <= out_q;
         endcase

         if (!err_q && (underflow || (sts_valid_i && sts_bad))) begin
            err_q     <= 1'b1;
            err_tag_q <= underflow ? 4'd0 : sts_data_i[3:0];
         end
      end
   end

endmodule
